// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared RV32 core types and constants used by the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int               XLEN      = 32;
    localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0]  PC_INCR   = 32'd4;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HELD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Fetch-stage bundle: hazard controls, imem bus and IF/ID outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface if_stage_if #(
    parameter int N = rv_pkg::XLEN
);
    logic         ifid_stall;
    logic         flush;
    logic [N-1:0] branch_target;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_rvalid;
    logic [N-1:0] imem_rdata;
    logic [N-1:0] ifid_instr;
    logic [N-1:0] ifid_pc;
    logic         ifid_valid;

    modport master (
        input  ifid_stall, flush, branch_target, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, ifid_instr, ifid_pc, ifid_valid
    );

    modport slave (
        output ifid_stall, flush, branch_target, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, ifid_instr, ifid_pc, ifid_valid
    );
endinterface
`default_nettype wire

// File: rtl/if_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_reg
// Brief    : IF/ID pipeline register with flush, load, bubble and hold.
// Revision : 1.0 - initial release
// ============================================================================
module ifid_reg
    import rv_pkg::*;
#(
    parameter int           N   = XLEN,
    parameter logic [N-1:0] NOP = NOP_INSTR
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         i_flush,
    input  wire logic         i_load,
    input  wire logic         i_bubble,
    input  wire logic [N-1:0] i_instr,
    input  wire logic [N-1:0] i_pc,
    output logic      [N-1:0] o_instr,
    output logic      [N-1:0] o_pc,
    output logic              o_valid
);

    logic [N-1:0] r_instr;
    logic [N-1:0] r_pc;
    logic         r_valid;

    // Flush outranks load; with none of the controls set the register holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_valid <= 1'b1;
        end else if (i_bubble) begin
            r_instr <= NOP;
            r_pc    <= i_pc;
            r_valid <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : RV32 instruction fetch: PC, single-outstanding imem FSM, IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage
    import rv_pkg::*;
#(
    parameter int           N        = XLEN,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] NOP      = NOP_INSTR
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    if_stage_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [N-1:0] r_pc;
    logic [N-1:0] w_pc_nxt;
    logic [N-1:0] r_hold;
    logic [N-1:0] w_hold_nxt;
    logic [N-1:0] w_redirect;
    logic [N-1:0] w_pc_inc;
    logic [N-1:0] w_load_instr;
    logic         w_load;
    logic         w_bubble;
    logic         w_kill;
    logic         w_unused_tgt;

    assign w_redirect   = {bus.branch_target[N-1:2], 2'b00};
    assign w_unused_tgt = ^bus.branch_target[1:0];
    assign w_pc_inc     = r_pc + N'(PC_INCR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
            r_hold  <= NOP;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_hold_nxt   = r_hold;
        w_load_instr = bus.imem_rdata;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_kill       = 1'b0;

        if (bus.flush) begin
            w_kill   = 1'b1;
            w_pc_nxt = w_redirect;
            // An un-answered request must be drained so its stale word is not
            // mistaken for the redirect target's response.
            case (r_state)
                WAIT, DRAIN: w_state_nxt = bus.imem_rvalid ? REQ : DRAIN;
                default:     w_state_nxt = REQ;
            endcase
        end else begin
            case (r_state)
                REQ: w_state_nxt = WAIT;
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (bus.ifid_stall) begin
                            w_hold_nxt  = bus.imem_rdata;
                            w_state_nxt = HELD;
                        end else begin
                            w_load      = 1'b1;
                            w_pc_nxt    = w_pc_inc;
                            w_state_nxt = REQ;
                        end
                    end
                end
                HELD: begin
                    if (!bus.ifid_stall) begin
                        w_load       = 1'b1;
                        w_load_instr = r_hold;
                        w_pc_nxt     = w_pc_inc;
                        w_state_nxt  = REQ;
                    end
                end
                DRAIN: begin
                    if (bus.imem_rvalid) begin
                        w_state_nxt = REQ;
                    end
                end
                default: w_state_nxt = REQ;
            endcase
            w_bubble = !bus.ifid_stall && !w_load;
        end
    end

    assign bus.imem_req  = (r_state == REQ);
    assign bus.imem_addr = r_pc;

    ifid_reg #(
        .N   (N),
        .NOP (NOP)
    ) u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (w_kill),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_instr  (w_load_instr),
        .i_pc     (r_pc),
        .o_instr  (bus.ifid_instr),
        .o_pc     (bus.ifid_pc),
        .o_valid  (bus.ifid_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage with a latency-variable imem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    if_stage_if #(.N(32)) bus();

    if_stage #(
        .N        (32),
        .RESET_PC (32'h0),
        .NOP      (C_NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        s_req;
    logic [31:0] s_addr, s_instr, s_pc;
    logic        s_valid;
    int          mem_lat   = 1;
    bit          mem_const = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_pend  = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_const) return 32'h0050_0093;
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    // Samples DUT outputs mid-cycle, then drives the memory response for this cycle.
    // The memory answers only its most recent request.
    task automatic tick();
        @(negedge clk);
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_instr = bus.ifid_instr;
        s_pc    = bus.ifid_pc;
        s_valid = bus.ifid_valid;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(mem_pend);
            end
        end
        if (s_req && rst_n) begin
            mem_pend = s_addr;
            mem_cnt  = mem_lat;
        end
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus.ifid_stall    = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_target = '0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = '0;
        mem_cnt           = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0 || s_instr !== C_NOP || s_pc !== 32'h0 || s_valid !== 1'b0)
            begin n_fail++; $display("FAIL reset_values: got req=%b addr=%h instr=%h pc=%h v=%b want 1/0/00000013/0/0", s_req, s_addr, s_instr, s_pc, s_valid); end
        mem_const = 1'b0; mem_lat = 2;
        do_reset();
        repeat (4) tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== mem_word(32'h0))
            begin n_fail++; $display("FAIL reset_pre: got v=%b pc=%h instr=%h want 1/0/%h", s_valid, s_pc, s_instr, mem_word(32'h0)); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== C_NOP)
            begin n_fail++; $display("FAIL reset_async: got req=%b addr=%h v=%b instr=%h want 1/0/0/00000013", bus.imem_req, bus.imem_addr, bus.ifid_valid, bus.ifid_instr); end
    endtask

    task automatic test_basic();
        logic        e_req, e_valid;
        logic [31:0] e_pc;
        mem_const = 1'b1; mem_lat = 1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            tick();
            e_req   = (c % 2 == 0);
            e_valid = (c >= 2) && (c % 2 == 0);
            n_checks++;
            if (s_req !== e_req || s_valid !== e_valid)
                begin n_fail++; $display("FAIL basic_strobes c%0d: got req=%b v=%b want req=%b v=%b", c, s_req, s_valid, e_req, e_valid); end
            if (e_req) begin
                n_checks++;
                if (s_addr !== 32'(4 * (c / 2)))
                    begin n_fail++; $display("FAIL basic_addr c%0d: got %h want %h", c, s_addr, 32'(4 * (c / 2))); end
            end
            if (e_valid) begin
                e_pc = 32'(4 * (c / 2 - 1));
                n_checks++;
                if (s_instr !== 32'h0050_0093 || s_pc !== e_pc)
                    begin n_fail++; $display("FAIL basic_ifid c%0d: got %h/%h want 00500093/%h", c, s_instr, s_pc, e_pc); end
            end
        end
        mem_const = 1'b0;
    endtask

    task automatic test_stall();
        mem_lat = 1;
        do_reset();
        repeat (5) tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h8)
            begin n_fail++; $display("FAIL stall_pre_addr: got req=%b addr=%h want 1/8", s_req, s_addr); end
        bus.ifid_stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h4 || s_instr !== mem_word(32'h4))
                begin n_fail++; $display("FAIL stall_hold s%0d: got req=%b v=%b pc=%h instr=%h want 0/1/4/%h", c, s_req, s_valid, s_pc, s_instr, mem_word(32'h4)); end
        end
        bus.ifid_stall = 1'b0;
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hC || s_valid !== 1'b1 || s_pc !== 32'h8 || s_instr !== mem_word(32'h8))
            begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h v=%b pc=%h instr=%h want 1/c/1/8/%h", s_req, s_addr, s_valid, s_pc, s_instr, mem_word(32'h8)); end
    endtask

    task automatic test_flush_wait();
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        bus.flush = 1'b1; bus.branch_target = 32'h100;
        for (int c = 2; c < 8; c++) begin
            tick();
            bus.flush = 1'b0;
            n_checks++;
            if (s_valid !== 1'b0 || s_instr !== C_NOP)
                begin n_fail++; $display("FAIL flushw_stale c%0d: got v=%b instr=%h want 0/00000013", c, s_valid, s_instr); end
            n_checks++;
            if (s_req !== (c == 4) || (c == 4 && s_addr !== 32'h100))
                begin n_fail++; $display("FAIL flushw_req c%0d: got req=%b addr=%h want req=%b addr=100", c, s_req, s_addr, (c == 4)); end
        end
        tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== mem_word(32'h100))
            begin n_fail++; $display("FAIL flushw_target: got v=%b pc=%h instr=%h want 1/100/%h", s_valid, s_pc, s_instr, mem_word(32'h100)); end
    endtask

    task automatic test_flush_rvalid();
        mem_lat = 2;
        do_reset();
        repeat (3) tick();
        bus.flush = 1'b1; bus.branch_target = 32'h100;
        tick();
        bus.flush = 1'b0;
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0 || s_pc !== 32'h0 || s_instr !== C_NOP)
            begin n_fail++; $display("FAIL flushr_redirect: got req=%b addr=%h v=%b pc=%h instr=%h want 1/100/0/0/00000013", s_req, s_addr, s_valid, s_pc, s_instr); end
        repeat (3) tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== mem_word(32'h100))
            begin n_fail++; $display("FAIL flushr_target: got v=%b pc=%h instr=%h want 1/100/%h", s_valid, s_pc, s_instr, mem_word(32'h100)); end
    endtask

    task automatic test_flush_held();
        mem_lat = 1;
        do_reset();
        tick();
        tick();
        bus.ifid_stall = 1'b1;
        tick();
        n_checks++;
        if (s_req !== 1'b0)
            begin n_fail++; $display("FAIL held_noreq: got req=%b want 0", s_req); end
        bus.flush = 1'b1; bus.branch_target = 32'h100;
        tick();
        bus.flush = 1'b0;
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0 || s_pc !== 32'h0 || s_instr !== C_NOP)
            begin n_fail++; $display("FAIL held_redirect: got req=%b addr=%h v=%b pc=%h instr=%h want 1/100/0/0/00000013", s_req, s_addr, s_valid, s_pc, s_instr); end
        tick();
        bus.ifid_stall = 1'b0;
        n_checks++;
        if (s_valid !== 1'b0 || s_instr !== C_NOP || s_pc !== 32'h0)
            begin n_fail++; $display("FAIL held_stallkeep: got v=%b instr=%h pc=%h want 0/00000013/0", s_valid, s_instr, s_pc); end
        tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== mem_word(32'h100))
            begin n_fail++; $display("FAIL held_target: got v=%b pc=%h instr=%h want 1/100/%h", s_valid, s_pc, s_instr, mem_word(32'h100)); end
    endtask

    task automatic test_wrap();
        mem_lat = 1;
        do_reset();
        tick();
        bus.flush = 1'b1; bus.branch_target = 32'hFFFF_FFFF;
        tick();
        bus.flush = 1'b0;
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL wrap_align: got req=%b addr=%h want 1/fffffffc", s_req, s_addr); end
        tick();
        tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFFC || s_req !== 1'b1 || s_addr !== 32'h0)
            begin n_fail++; $display("FAIL wrap_next: got v=%b pc=%h req=%b addr=%h want 1/fffffffc/1/0", s_valid, s_pc, s_req, s_addr); end
        bus.flush = 1'b1; bus.branch_target = 32'h103;
        tick();
        bus.flush = 1'b0;
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100)
            begin n_fail++; $display("FAIL wrap_target103: got req=%b addr=%h want 1/100", s_req, s_addr); end
        tick();
        tick();
        n_checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== mem_word(32'h100))
            begin n_fail++; $display("FAIL wrap_deliver: got v=%b pc=%h instr=%h want 1/100/%h", s_valid, s_pc, s_instr, mem_word(32'h100)); end
    endtask

    // Reference: the fetch stream is sequential from the last redirect; every
    // delivered entry is that address's memory word; stall freezes IF/ID; flush empties it.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] p_instr, p_pc;
        logic        p_valid;
        bit          p_stall, p_flush;
        do_reset();
        exp_pc  = 32'h0;
        p_stall = 1'b0; p_flush = 1'b0;
        p_instr = C_NOP; p_pc = '0; p_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (p_flush) begin
                n_checks++;
                if (s_valid !== 1'b0 || s_instr !== C_NOP || s_pc !== 32'h0)
                    begin n_fail++; $display("FAIL rnd_flush c%0d: got v=%b instr=%h pc=%h want 0/00000013/0", c, s_valid, s_instr, s_pc); end
            end else if (p_stall) begin
                n_checks++;
                if (s_valid !== p_valid || s_instr !== p_instr || s_pc !== p_pc)
                    begin n_fail++; $display("FAIL rnd_stall c%0d: got %b/%h/%h want %b/%h/%h", c, s_valid, s_instr, s_pc, p_valid, p_instr, p_pc); end
            end else if (s_valid === 1'b1) begin
                n_checks++;
                if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc))
                    begin n_fail++; $display("FAIL rnd_deliver c%0d: got pc=%h instr=%h want %h/%h", c, s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
            end
            if (s_valid !== 1'b1) begin
                n_checks++;
                if (s_instr !== C_NOP)
                    begin n_fail++; $display("FAIL rnd_bubble c%0d: got instr=%h want 00000013", c, s_instr); end
            end
            if (s_req === 1'b1) begin
                n_checks++;
                if (s_addr !== exp_pc)
                    begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, s_addr, exp_pc); end
            end
            p_instr = s_instr; p_pc = s_pc; p_valid = s_valid;
            mem_lat           = int'($urandom_range(1, 3));
            bus.ifid_stall    = ($urandom_range(0, 2) == 0);
            bus.flush         = ($urandom_range(0, 15) == 0);
            bus.branch_target = $urandom;
            if (bus.flush) exp_pc = {bus.branch_target[31:2], 2'b00};
            p_stall = bus.ifid_stall;
            p_flush = bus.flush;
        end
        bus.ifid_stall = 1'b0;
        bus.flush      = 1'b0;
    endtask

    initial begin
        bus.ifid_stall    = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_target = '0;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = '0;
        test_reset();
        test_basic();
        test_stall();
        test_flush_wait();
        test_flush_rvalid();
        test_flush_held();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
